// File: rtl/barrel_shifter.sv
// Crossbar select decoder: each output lane registers a one-hot select vector
// decoded from its route index. Reset loads the identity mapping.
module barrel_shifter #(
  parameter  int unsigned N          = 8,
  localparam int unsigned ROUTE_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ROUTE_BITS-1:0] route     [N],
  output logic [N-1:0]          select_SE [N]
);

  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] w_next [N];
  logic [N-1:0] r_sel  [N];

  // Per-lane decode; an index past the last input falls back to input 0.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_next[j] = ONE_HOT_0;
      if (32'(route[j]) < N) begin
        w_next[j] = ONE_HOT_0 << route[j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        r_sel[j] <= ONE_HOT_0 << j;
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        r_sel[j] <= w_next[j];
      end
    end
  end

  assign select_SE = r_sel;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed bench for barrel_shifter (N=8): checks exact select value, one-hot
// count and the routed bit for every lane after each step.
module tb_barrel_shifter;

  typedef logic [7:0] lane_t [8];
  typedef int         idx_t  [8];

  logic       clk;
  logic       rst;
  logic [2:0] route [8];
  logic [7:0] sel   [8];

  int vecs;
  int errs;

  barrel_shifter #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .route     (route),
    .select_SE (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_route(input idx_t r);
    for (int j = 0; j < 8; j++) route[j] = 3'(r[j]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input lane_t exp, input idx_t idx);
    for (int j = 0; j < 8; j++) begin
      vecs++;
      assert (sel[j] === exp[j]) else begin
        errs++;
        $error("FAIL %s value lane %0d: got %b expected %b", tag, j, sel[j], exp[j]);
      end
      vecs++;
      assert ($countones(sel[j]) === 1) else begin
        errs++;
        $error("FAIL %s onehot lane %0d: got %b (popcount %0d) expected popcount 1",
               tag, j, sel[j], $countones(sel[j]));
      end
      vecs++;
      assert (sel[j][3'(idx[j])] === 1'b1) else begin
        errs++;
        $error("FAIL %s routebit lane %0d: got %b expected bit %0d set", tag, j, sel[j], idx[j]);
      end
    end
  endtask

  initial begin
    idx_t  r_ident, r_zero, r_dist, r_rev, r_mix, r_sevens;
    lane_t e_ident, e_zero, e_dist, e_rev, e_mix;

    vecs = 0;
    errs = 0;

    r_ident  = '{0, 1, 2, 3, 4, 5, 6, 7};
    r_zero   = '{0, 0, 0, 0, 0, 0, 0, 0};
    r_dist   = '{3, 1, 7, 0, 2, 6, 5, 4};
    r_rev    = '{7, 6, 5, 4, 3, 2, 1, 0};
    r_mix    = '{7, 6, 2, 4, 3, 2, 1, 0};
    r_sevens = '{7, 7, 7, 7, 7, 7, 7, 7};

    e_ident = '{8'b00000001, 8'b00000010, 8'b00000100, 8'b00001000,
                8'b00010000, 8'b00100000, 8'b01000000, 8'b10000000};
    e_zero  = '{8'b00000001, 8'b00000001, 8'b00000001, 8'b00000001,
                8'b00000001, 8'b00000001, 8'b00000001, 8'b00000001};
    e_dist  = '{8'b00001000, 8'b00000010, 8'b10000000, 8'b00000001,
                8'b00000100, 8'b01000000, 8'b00100000, 8'b00010000};
    e_rev   = '{8'b10000000, 8'b01000000, 8'b00100000, 8'b00010000,
                8'b00001000, 8'b00000100, 8'b00000010, 8'b00000001};
    e_mix   = '{8'b10000000, 8'b01000000, 8'b00000100, 8'b00010000,
                8'b00001000, 8'b00000100, 8'b00000010, 8'b00000001};

    // Reset overrides a non-identity route.
    rst = 1'b1;
    set_route(r_sevens);
    step();
    check("reset", e_ident, r_ident);

    // First edge out of reset loads the decode of the current route.
    rst = 1'b0;
    set_route(r_ident);
    step();
    check("identity", e_ident, r_ident);

    set_route(r_zero);
    step();
    check("allzero", e_zero, r_zero);

    set_route(r_dist);
    step();
    check("distinct", e_dist, r_dist);

    // Reconfiguration: value holds between edges, then all lanes update together.
    set_route(r_zero);
    step();
    check("reconf_pre", e_zero, r_zero);
    set_route(r_rev);
    #2;
    check("reconf_hold", e_zero, r_zero);
    step();
    check("reconf_post", e_rev, r_rev);

    // Only lane 2 changes.
    set_route(r_mix);
    step();
    check("lane_indep", e_mix, r_mix);

    // Reset in mid-operation discards the route present at that edge.
    set_route(r_rev);
    rst = 1'b1;
    step();
    check("midreset", e_ident, r_ident);
    rst = 1'b0;
    step();
    check("post_reset", e_rev, r_rev);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/barrel_shifter.md
BARREL_SHIFTER -- requirements
Module: barrel_shifter

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the number of crossbar inputs and outputs; N SHALL be at least 2.
REQ-002 The block SHALL derive a non-overridable constant ROUTE_BITS = ceil(log2(N)), which is 3 for N=8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 route  input  unpacked array [N] of ROUTE_BITS  route[j] = index of the input that output j selects.
REQ-006 select_SE  output  unpacked array [N] of N bits  select_SE[j] = one-hot select vector for output j's switch element; bit i set means input i is selected.

Function
REQ-007 The block SHALL decode each lane j independently: the next value of select_SE[j] SHALL equal 1 shifted left by route[j].
REQ-008 select_SE SHALL be registered: a route value present at rising edge k SHALL appear on select_SE immediately after edge k, giving a latency of 1 clock.
REQ-009 Between edges, select_SE SHALL hold its last registered value regardless of route changes.
REQ-010 Every select_SE[j] SHALL be exactly one-hot at all times after the first edge with rst asserted; the one-hot count SHALL never be 0 and never be greater than 1.
REQ-011 The block SHALL NOT detect or resolve collisions; several outputs selecting the same input is legal, and each such lane SHALL still be one-hot.
REQ-012 Lanes SHALL be fully independent; a change to route[j] SHALL affect only select_SE[j].
REQ-013 Out-of-range routes occur only when N is not a power of two: if route[j] >= N, the next select_SE[j] SHALL be one-hot bit 0, i.e. input 0.
REQ-014 The block SHALL accept a full reconfiguration of all N routes in one cycle, with all lanes updating on the same edge.
REQ-015 The block SHALL contain no other state, handshake or backpressure; it updates every cycle when rst is low.

Reset
REQ-016 While rst is high at a rising edge, select_SE[j] SHALL load 1 shifted left by j (identity mapping), overriding route.
REQ-017 If rst is asserted in the middle of operation, the reset SHALL take effect at the next rising edge, and the route present at that edge SHALL be discarded.
REQ-018 On the first edge with rst low, select_SE SHALL load the decode of the current route.
REQ-019 Before the first reset edge, select_SE is undefined; the bench SHALL NOT check it.

Verification
REQ-020 Identity: N=8, route[j]=j, one edge -> select_SE[j] = 1 shifted left by j, e.g. select_SE[3]=00001000; every lane one-hot.
REQ-021 All-zero: route[j]=0 for all j, one edge -> every select_SE[j]=00000001; no error, since collisions are legal.
REQ-022 Distinct simultaneous: route=[3,1,7,0,2,6,5,4] -> select_SE[0]=00001000, [1]=00000010, [2]=10000000, [3]=00000001, [4]=00000100, [5]=01000000, [6]=00100000, [7]=00010000.
REQ-023 Reconfiguration: all routes 0, edge, then route=[7,6,5,4,3,2,1,0] -> before the next edge select_SE still reads all 00000001; after that edge select_SE[j] = 1 shifted left by (7-j), e.g. select_SE[0]=10000000.
REQ-024 Reset mid-operation: route=[7..0] with rst=1 at an edge -> select_SE[j] = 1 shifted left by j (identity); release rst -> the next edge loads the reversed mapping.
REQ-025 Every check SHALL assert both one-hot (popcount = 1) and select_SE[j][route[j]] = 1, using the route sampled at the previous edge.
